// File: rtl/mem_except_stage_if.sv
// Bundle between the EX/MEM pipeline register and its neighbours: EX-side
// instruction fields and control in, CP0-facing exception info out.
interface mem_except_stage_if #(parameter int PC_W = 32);
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_if_adel;
    logic            ex_ri;
    logic            ex_ov;
    logic            ex_syscall;
    logic            ex_break;
    logic            ex_eret;
    logic            ex_mfc0;
    logic            ex_mtc0;
    logic [4:0]      ex_cp0_addr;
    logic            ex_is_load;
    logic            ex_is_store;
    logic [1:0]      ex_mem_size;
    logic [PC_W-1:0] ex_mem_addr;
    logic [PC_W-1:0] ex_rt_rdata;

    logic [14:0]     excepttype;
    logic [PC_W-1:0] current_pc;
    logic [PC_W-1:0] bad_addr;
    logic [PC_W-1:0] rt_rdata;
    logic            out_valid;
    logic            mem_en_ok;

    modport master (
        output stall, flush, ex_valid, ex_pc, ex_is_branch, ex_if_adel, ex_ri,
               ex_ov, ex_syscall, ex_break, ex_eret, ex_mfc0, ex_mtc0,
               ex_cp0_addr, ex_is_load, ex_is_store, ex_mem_size,
               ex_mem_addr, ex_rt_rdata,
        input  excepttype, current_pc, bad_addr, rt_rdata, out_valid, mem_en_ok
    );

    modport slave (
        input  stall, flush, ex_valid, ex_pc, ex_is_branch, ex_if_adel, ex_ri,
               ex_ov, ex_syscall, ex_break, ex_eret, ex_mfc0, ex_mtc0,
               ex_cp0_addr, ex_is_load, ex_is_store, ex_mem_size,
               ex_mem_addr, ex_rt_rdata,
        output excepttype, current_pc, bad_addr, rt_rdata, out_valid, mem_en_ok
    );
endinterface

// File: rtl/mem_except_stage.sv
// EX->MEM pipeline register that merges all exception sources of an
// instruction into one prioritised cause and gates its data-SRAM access.
module mem_except_stage #(
    parameter int PC_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_except_stage_if.slave bus
);

    logic            w_mis;
    logic            w_dataAdel;
    logic            w_dataAdes;
    logic [5:0]      w_cause;
    logic            w_anyExc;
    logic            w_eret;
    logic            w_mfc0;
    logic            w_mtc0;
    logic [4:0]      w_cp0Addr;
    logic [PC_W-1:0] w_badAddr;
    logic [14:0]     w_excepttype;
    logic            w_memEnOk;
    logic            w_accept;

    logic            r_lastWasBranch;
    logic            r_outValid;
    logic            r_memEnOk;
    logic [14:0]     r_excepttype;
    logic [PC_W-1:0] r_currentPc;
    logic [PC_W-1:0] r_badAddr;
    logic [PC_W-1:0] r_rtRdata;

    // w_cause is bits [8:3] of excepttype: {ades, adel, ov, syscall, break, ri}
    always_comb begin
        w_mis = ((bus.ex_mem_size == 2'b01) & bus.ex_mem_addr[0]) |
                ((bus.ex_mem_size == 2'b10) & (bus.ex_mem_addr[1:0] != 2'b00));
        w_dataAdel = bus.ex_is_load  & w_mis;
        w_dataAdes = bus.ex_is_store & w_mis;

        w_cause   = 6'b000000;
        w_badAddr = '0;
        if (bus.ex_if_adel) begin
            w_cause[4] = 1'b1;
            w_badAddr  = bus.ex_pc;
        end else if (bus.ex_ri) begin
            w_cause[0] = 1'b1;
        end else if (bus.ex_ov) begin
            w_cause[3] = 1'b1;
        end else if (bus.ex_syscall) begin
            w_cause[2] = 1'b1;
        end else if (bus.ex_break) begin
            w_cause[1] = 1'b1;
        end else if (w_dataAdel) begin
            w_cause[4] = 1'b1;
            w_badAddr  = bus.ex_mem_addr;
        end else if (w_dataAdes) begin
            w_cause[5] = 1'b1;
            w_badAddr  = bus.ex_mem_addr;
        end

        // A real exception suppresses the CP0-access side effects entirely
        w_anyExc  = |w_cause;
        w_eret    = bus.ex_eret & ~w_anyExc;
        w_mfc0    = bus.ex_mfc0 & ~w_anyExc;
        w_mtc0    = bus.ex_mtc0 & ~w_anyExc;
        w_cp0Addr = (w_mfc0 | w_mtc0) ? bus.ex_cp0_addr : 5'd0;

        w_excepttype = {w_cp0Addr, r_lastWasBranch, w_cause, w_eret, w_mfc0, w_mtc0};
        w_memEnOk    = (bus.ex_is_load | bus.ex_is_store) & ~w_anyExc;
        w_accept     = bus.ex_valid & ~bus.stall & ~bus.flush;
    end

    // Bubbles clear the outputs but keep r_lastWasBranch so a delay slot
    // behind bubbles is still recognised; only flush forgets the branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastWasBranch <= 1'b0;
            r_outValid      <= 1'b0;
            r_memEnOk       <= 1'b0;
            r_excepttype    <= '0;
            r_currentPc     <= '0;
            r_badAddr       <= '0;
            r_rtRdata       <= '0;
        end else if (bus.flush) begin
            r_lastWasBranch <= 1'b0;
            r_outValid      <= 1'b0;
            r_memEnOk       <= 1'b0;
            r_excepttype    <= '0;
            r_currentPc     <= '0;
            r_badAddr       <= '0;
            r_rtRdata       <= '0;
        end else if (!bus.stall) begin
            if (w_accept) begin
                r_lastWasBranch <= bus.ex_is_branch;
                r_outValid      <= 1'b1;
                r_memEnOk       <= w_memEnOk;
                r_excepttype    <= w_excepttype;
                r_currentPc     <= bus.ex_pc;
                r_badAddr       <= w_badAddr;
                r_rtRdata       <= bus.ex_rt_rdata;
            end else begin
                r_outValid      <= 1'b0;
                r_memEnOk       <= 1'b0;
                r_excepttype    <= '0;
                r_currentPc     <= '0;
                r_badAddr       <= '0;
                r_rtRdata       <= '0;
            end
        end
    end

    assign bus.out_valid  = r_outValid;
    assign bus.mem_en_ok  = r_memEnOk;
    assign bus.excepttype = r_excepttype;
    assign bus.current_pc = r_currentPc;
    assign bus.bad_addr   = r_badAddr;
    assign bus.rt_rdata   = r_rtRdata;

endmodule

// File: tb/tb_mem_except_stage.sv
// Scoreboard bench for mem_except_stage: directed cases plus random traffic
// checked against a cause-priority reference model.
module tb_mem_except_stage;

    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit        isBranch;
        bit        ifAdel;
        bit        ri;
        bit        ov;
        bit        sys;
        bit        brk;
        bit        eret;
        bit        mfc0;
        bit        mtc0;
        bit [4:0]  cp0Addr;
        bit        isLoad;
        bit        isStore;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] rt;
    } stim_t;

    typedef struct packed {
        logic [14:0] et;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] rt;
        logic        valid;
        logic        memOk;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t expQ[$];
    exp_t prevExp;
    bit   lastBranch;

    mem_except_stage_if #(.PC_W(32)) bus ();

    mem_except_stage #(.PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t blank();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic exp_t sampleDut();
        exp_t a;
        a.et    = bus.excepttype;
        a.pc    = bus.current_pc;
        a.bad   = bus.bad_addr;
        a.rt    = bus.rt_rdata;
        a.valid = bus.out_valid;
        a.memOk = bus.mem_en_ok;
        return a;
    endfunction

    // Reference: pick the winning cause by walking the priority list
    function automatic exp_t modelAccept(stim_t s, bit ds);
        exp_t e;
        int   win;
        bit   mis;
        e   = '0;
        mis = (s.size == 2'd1 && s.addr[0]) || (s.size == 2'd2 && s.addr[1:0] != 2'd0);
        win = -1;
        if (s.ifAdel) begin
            win = 7; e.bad = s.pc;
        end else if (s.ri) win = 3;
        else if (s.ov) win = 6;
        else if (s.sys) win = 5;
        else if (s.brk) win = 4;
        else if (s.isLoad && mis) begin
            win = 7; e.bad = s.addr;
        end else if (s.isStore && mis) begin
            win = 8; e.bad = s.addr;
        end
        if (win >= 0) begin
            e.et[win] = 1'b1;
        end else begin
            e.et[2] = s.eret;
            e.et[1] = s.mfc0;
            e.et[0] = s.mtc0;
            if (s.mfc0 || s.mtc0) e.et[14:10] = s.cp0Addr;
        end
        e.et[9] = ds;
        e.pc    = s.pc;
        e.rt    = s.rt;
        e.valid = 1'b1;
        e.memOk = (s.isLoad || s.isStore) && (win < 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t exp);
        exp_t act;
        act   = sampleDut();
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got et=%h pc=%h bad=%h rt=%h v=%b mem=%b, expected et=%h pc=%h bad=%h rt=%h v=%b mem=%b",
                     name, act.et, act.pc, act.bad, act.rt, act.valid, act.memOk,
                     exp.et, exp.pc, exp.bad, exp.rt, exp.valid, exp.memOk);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then record what the stage must show after the edge
    task automatic applyStimulus(input stim_t s, input bit stall, input bit flush);
        exp_t e;
        bus.stall        = stall;
        bus.flush        = flush;
        bus.ex_valid     = s.valid;
        bus.ex_pc        = s.pc;
        bus.ex_is_branch = s.isBranch;
        bus.ex_if_adel   = s.ifAdel;
        bus.ex_ri        = s.ri;
        bus.ex_ov        = s.ov;
        bus.ex_syscall   = s.sys;
        bus.ex_break     = s.brk;
        bus.ex_eret      = s.eret;
        bus.ex_mfc0      = s.mfc0;
        bus.ex_mtc0      = s.mtc0;
        bus.ex_cp0_addr  = s.cp0Addr;
        bus.ex_is_load   = s.isLoad;
        bus.ex_is_store  = s.isStore;
        bus.ex_mem_size  = s.size;
        bus.ex_mem_addr  = s.addr;
        bus.ex_rt_rdata  = s.rt;
        @(posedge clk);
        if (flush) begin
            e = '0;
            lastBranch = 1'b0;
        end else if (stall) begin
            e = prevExp;
        end else if (s.valid) begin
            e = modelAccept(s, lastBranch);
            lastBranch = s.isBranch;
        end else begin
            e = '0;
        end
        prevExp = e;
        expQ.push_back(e);
        #1;
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s          = blank();
        s.valid    = ($urandom % 4) != 0;
        s.pc       = $urandom;
        s.isBranch = ($urandom % 3) == 0;
        s.ifAdel   = ($urandom % 10) == 0;
        s.ri       = ($urandom % 10) == 0;
        s.ov       = ($urandom % 10) == 0;
        s.sys      = ($urandom % 10) == 0;
        s.brk      = ($urandom % 10) == 0;
        s.eret     = ($urandom % 8) == 0;
        s.mfc0     = ($urandom % 5) == 0;
        s.mtc0     = ($urandom % 5) == 0;
        s.cp0Addr  = 5'($urandom);
        case ($urandom % 3)
            0: s.isLoad = 1'b1;
            1: s.isStore = 1'b1;
            default: ;
        endcase
        s.size = 2'($urandom % 4);
        s.addr = $urandom;
        s.rt   = $urandom;
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput("pipe", expQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        exp_t  zero;
        total      = 0;
        bad        = 0;
        zero       = '0;
        prevExp    = '0;
        lastBranch = 1'b0;
        rst        = 1'b1;
        s          = blank();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_pc = '0;
        bus.ex_is_branch = 1'b0; bus.ex_if_adel = 1'b0; bus.ex_ri = 1'b0; bus.ex_ov = 1'b0;
        bus.ex_syscall = 1'b0; bus.ex_break = 1'b0; bus.ex_eret = 1'b0; bus.ex_mfc0 = 1'b0;
        bus.ex_mtc0 = 1'b0; bus.ex_cp0_addr = '0; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0;
        bus.ex_mem_size = '0; bus.ex_mem_addr = '0; bus.ex_rt_rdata = '0;
        #3;
        checkOutput("reset", zero);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] reset released");

        s = blank(); s.valid = 1; s.pc = 32'hBFC00100; s.isLoad = 1; s.size = 2'd2;
        s.addr = 32'h80000002; s.rt = 32'h12345678;
        applyStimulus(s, 0, 0);
        checkValue("load_adel_et", {17'd0, bus.excepttype}, 32'h0080);
        checkValue("load_adel_bad", bus.bad_addr, 32'h80000002);

        s = blank(); s.valid = 1; s.pc = 32'h100; s.isBranch = 1;
        applyStimulus(s, 0, 0);
        applyStimulus(blank(), 0, 0);
        s = blank(); s.valid = 1; s.pc = 32'h104; s.sys = 1;
        applyStimulus(s, 0, 0);
        checkValue("delayslot_sys", {17'd0, bus.excepttype}, 32'h0220);

        s = blank(); s.valid = 1; s.pc = 32'h101; s.ifAdel = 1; s.ov = 1;
        s.isStore = 1; s.size = 2'd2; s.addr = 32'h00000203;
        applyStimulus(s, 0, 0);
        checkValue("fetch_adel_et", {17'd0, bus.excepttype}, 32'h0080);
        checkValue("fetch_adel_bad", bus.bad_addr, 32'h101);

        s = blank(); s.valid = 1; s.pc = 32'h200; s.mtc0 = 1; s.cp0Addr = 5'd12;
        applyStimulus(s, 0, 0);
        checkValue("mtc0_et", {17'd0, bus.excepttype}, 32'h3001);
        s.ri = 1;
        applyStimulus(s, 0, 0);
        checkValue("mtc0_ri_et", {17'd0, bus.excepttype}, 32'h0008);

        s = blank(); s.valid = 1; s.pc = 32'h300; s.ov = 1; s.isBranch = 1; s.rt = 32'hCAFE;
        applyStimulus(s, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(blank(), 1, 0);
            checkValue("stall_hold_et", {17'd0, bus.excepttype}, 32'h0040);
        end
        applyStimulus(blank(), 1, 1);
        checkValue("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        s = blank(); s.valid = 1; s.pc = 32'h304;
        applyStimulus(s, 0, 0);
        checkValue("after_flush_et", {17'd0, bus.excepttype}, 32'h0000);

        s = blank(); s.valid = 1; s.pc = 32'h400; s.ov = 1; s.rt = 32'hBEEF;
        applyStimulus(s, 0, 0);
        applyStimulus(blank(), 1, 0);
        #1;
        expQ.delete();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", zero);
        @(posedge clk); #1;
        rst = 1'b0;
        prevExp    = '0;
        lastBranch = 1'b0;

        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim(), ($urandom % 5) == 0, ($urandom % 12) == 0);
        end

        repeat (2) @(negedge clk);
        #1;
        total = total + 1;
        if (expQ.size() != 0) begin
            bad = bad + 1;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_except_stage.md
Name: mem_except_stage

Overview:
- EX→MEM pipeline register that collects every exception source for one instruction.
- Detects data address misalignment and tracks branch delay slots.
- Prioritises the sources to a single cause and presents the packed 15-bit excepttype vector, current_pc, bad_addr and rt_rdata to the CP0 block.
- Also gates the data-SRAM access of any excepting instruction.

Parameters:
- PC_W, 32, width of PC, address and data buses.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold stage contents.
- flush  in  1  kill stage contents (from CP0 to_be_flushed); priority over stall.
- ex_valid  in  1  EX holds a real instruction.
- ex_pc  in  32  instruction PC.
- ex_is_branch  in  1  instruction is branch/jump; the next accepted instruction is its delay slot.
- ex_if_adel  in  1  fetch address error (PC misaligned).
- ex_ri  in  1  reserved instruction.
- ex_ov  in  1  arithmetic overflow.
- ex_syscall  in  1  syscall.
- ex_break  in  1  break.
- ex_eret  in  1  eret.
- ex_mfc0  in  1  mfc0.
- ex_mtc0  in  1  mtc0.
- ex_cp0_addr  in  5  CP0 register number.
- ex_is_load  in  1  load instruction.
- ex_is_store  in  1  store instruction.
- ex_mem_size  in  2  00 byte, 01 half, 10 word.
- ex_mem_addr  in  32  effective data address.
- ex_rt_rdata  in  32  rt operand.
- excepttype  out  15  {cp0_addr[4:0], delayslot, ades, adel, ov, syscall, break, ri, eret, mfc0, mtc0}.
- current_pc  out  32  registered PC.
- bad_addr  out  32  faulting virtual address.
- rt_rdata  out  32  registered rt.
- out_valid  out  1  stage holds a real instruction.
- mem_en_ok  out  1  data-SRAM access allowed.

Behaviour:
- Reset (async, rst=1): every output is 0 and the internal last_was_branch is 0.
- Latency: one cycle. An instruction is accepted at a posedge when ex_valid & ~stall & ~flush, and all outputs reflect it after that edge.
- flush=1 at an edge:
  - All outputs go to 0 (bubble) and last_was_branch clears.
  - Applies regardless of stall or ex_valid.
- stall=1 & flush=0: all outputs and last_was_branch hold.
- ex_valid=0, no stall, no flush: bubble is registered (outputs 0). last_was_branch holds, so a delay slot separated from its branch by bubbles is still flagged.
- Delay slot:
  - On accept, the registered delayslot bit = last_was_branch.
  - last_was_branch then takes ex_is_branch.
- Misalignment, evaluated on accept:
  - mis = (size 01 & addr[0]) | (size 10 & addr[1:0]≠0).
  - Data adel = ex_is_load & mis; data ades = ex_is_store & mis.
- Priority, high to low, and the resulting one-hot in bits [8:3]:
  - fetch adel (adel bit, bad_addr = ex_pc)
  - ri
  - ov
  - syscall
  - break
  - data adel (adel bit, bad_addr = ex_mem_addr)
  - ades (bad_addr = ex_mem_addr)
- Only the winning bit is set, so bits [8:3] are always zero or one-hot.
- bad_addr is 0 unless the winner is an address error.
- If any of [8:3] is set, the eret/mfc0/mtc0 bits are forced to 0. Otherwise they pass through.
- cp0_addr field = ex_cp0_addr when mfc0|mtc0, else 0.
- mem_en_ok = out_valid & (ex_is_load|ex_is_store registered) & (bits [8:3] all zero).
- current_pc and rt_rdata are registered copies; 0 for bubbles.
- Reset asserted mid-stall: outputs clear immediately, without waiting for an edge.

Test Plan:
- Word load, ex_pc=0xBFC00100, addr=0x80000002, ex_valid=1 → next cycle excepttype[7]=1, bits [8:3]=010000, bad_addr=0x80000002, current_pc=0xBFC00100, mem_en_ok=0.
- Branch at 0x100, then a syscall at 0x104 two cycles later with one bubble between → delayslot bit=1, excepttype=0x0220 (delayslot and syscall bits set).
- ex_if_adel, ex_ov and misaligned store all together, ex_pc=0x00000101 → only adel set, bad_addr=0x00000101, ades=0, ov=0.
- mtc0 with ex_cp0_addr=12, no exceptions → excepttype=0x3001, mem_en_ok=0. Same with ex_ri=1 → excepttype=0x0008.
- Stall for 3 cycles holding an ov instruction → outputs stable. Assert flush together with stall → next edge all outputs 0, and a following instruction is not flagged delayslot even if the previous one was a branch.
- Assert rst asynchronously mid-cycle while outputs are nonzero → all outputs 0 before the next clk edge.
